// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states, owner,
// load/store flag and the access-width code helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_STORE = 1'b1;

  // Width code is log2 of the access size in bytes (byte = 0).
  localparam int unsigned WDTH_BYTE = 0;

  function automatic int unsigned full_wdth_code(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_arb_arb_pick.sv
// Winner selection between IFU and LSU: fixed LSU priority by default, or
// round-robin on contention when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic adv_i,
`endif
  input  logic ifu_req_i,
  input  logic lsu_req_i,
  output logic pick_ifu_o,
  output logic pick_lsu_o
);

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  // On contention the requester that was not granted last wins.
  assign pick_lsu_o = lsu_req_i && (!ifu_req_i || (last_q == OWN_IFU));
  assign pick_ifu_o = ifu_req_i && !pick_lsu_o;

  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      last_d = pick_lsu_o ? OWN_LSU : OWN_IFU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWN_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_lsu_o = lsu_req_i;
  assign pick_ifu_o = ifu_req_i && !lsu_req_i;
`endif

endmodule

// File: rtl/mem_arb.sv
// IFU/LSU arbiter onto a single memory port with one outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of LSU priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int LSWDTH_LSULEN = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ifu_req_i,
  input  logic [ADDR_WIDTH-1:0]    ifu_addr_i,
  output logic                     ifu_gnt_o,
  output logic                     ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]    ifu_rdata_o,
  input  logic                     lsu_req_i,
  input  logic [ADDR_WIDTH-1:0]    lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
  input  logic [LSWDTH_LSULEN-1:0] lsu_wdth_i,
  input  logic                     lsu_ls_i,
  output logic                     lsu_gnt_o,
  output logic                     lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]    lsu_rdata_o,
  output logic                     mem_req_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic [LSWDTH_LSULEN-1:0] mem_wdth_o,
  output logic                     mem_ls_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  localparam logic [LSWDTH_LSULEN-1:0] WDTH_FULL =
    LSWDTH_LSULEN'(full_wdth_code(DATA_WIDTH));

  state_e                     state_q, state_d;
  owner_e                     owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [LSWDTH_LSULEN-1:0]   wdth_q, wdth_d;
  logic                       ls_q, ls_d;

  logic pick_ifu, pick_lsu;
  logic capture, ifu_win, lsu_win;
  logic issue, resp_done;

  arb_pick u_arb_pick (
`ifdef MEM_ARB_RR_EN
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (capture),
`endif
    .ifu_req_i  (ifu_req_i),
    .lsu_req_i  (lsu_req_i),
    .pick_ifu_o (pick_ifu),
    .pick_lsu_o (pick_lsu)
  );

  // Requests are only accepted from IDLE, so a completing RESP cycle never grants.
  assign capture   = rst_n && (state_q == ST_IDLE) && (ifu_req_i || lsu_req_i);
  assign lsu_win   = capture && pick_lsu;
  assign ifu_win   = capture && pick_ifu;
  assign issue     = (state_q == ST_ISSUE);
  assign resp_done = rst_n && (state_q == ST_RESP) && mem_rvalid_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wdth_d  = wdth_q;
    ls_d    = ls_q;
    unique case (state_q)
      ST_IDLE:  if (capture)      state_d = ST_ISSUE;
      ST_ISSUE: if (mem_gnt_i)    state_d = ST_RESP;
      ST_RESP:  if (mem_rvalid_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
    if (lsu_win) begin
      owner_d = OWN_LSU;
      addr_d  = lsu_addr_i;
      wdata_d = lsu_wdata_i;
      wdth_d  = lsu_wdth_i;
      ls_d    = lsu_ls_i;
    end else if (ifu_win) begin
      owner_d = OWN_IFU;
      addr_d  = ifu_addr_i;
      wdata_d = '0;
      wdth_d  = WDTH_FULL;
      ls_d    = LS_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Payload needs no reset: it only reaches the memory port while in ISSUE.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wdth_q  <= wdth_d;
    ls_q    <= ls_d;
  end

  assign ifu_gnt_o    = ifu_win;
  assign lsu_gnt_o    = lsu_win;

  assign mem_req_o    = issue;
  assign mem_addr_o   = issue ? addr_q  : '0;
  assign mem_wdata_o  = issue ? wdata_q : '0;
  assign mem_wdth_o   = issue ? wdth_q  : '0;
  assign mem_ls_o     = issue ? ls_q    : LS_LOAD;

  assign ifu_rvalid_o = resp_done && (owner_q == OWN_IFU);
  assign lsu_rvalid_o = resp_done && (owner_q == OWN_LSU);
  assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized self-checking bench for mem_arb against a transaction-level model
// of the arbitration rules (fixed LSU priority, or round-robin with MEM_ARB_RR_EN).
module tb_mem_arb;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_i, lsu_req_i, lsu_ls_i;
  logic [31:0] ifu_addr_i, lsu_addr_i;
  logic [63:0] lsu_wdata_i, mem_rdata_i;
  logic [2:0]  lsu_wdth_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic        ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
  logic [63:0] ifu_rdata_o, lsu_rdata_o, mem_wdata_o;
  logic        mem_req_o, mem_ls_o;
  logic [31:0] mem_addr_o;
  logic [2:0]  mem_wdth_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic last_lsu_m;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
    .ifu_gnt_o(ifu_gnt_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wdth_i(lsu_wdth_i), .lsu_ls_i(lsu_ls_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wdth_o(mem_wdth_o), .mem_ls_o(mem_ls_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {
    logic        ig;
    logic        lg;
    logic        mreq;
    logic        stable;
    logic        spur;
    logic [31:0] maddr;
    logic [63:0] mwdata;
    logic [2:0]  mwdth;
    logic        mls;
    logic        irv;
    logic        lrv;
    logic [63:0] ird;
    logic [63:0] lrd;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_lsu_m = 1'b0;
  endtask

  // One full transaction from IDLE: grant cycle, ISSUE (gd stall cycles),
  // RESP (rd idle cycles before the response). Observations come back in o.
  task automatic run_txn(input logic ireq, input logic [31:0] iaddr,
                         input logic lreq, input logic [31:0] laddr,
                         input logic [63:0] lwd, input logic [2:0] lw, input logic lls,
                         input int gd, input int rd, input logic [63:0] rdat,
                         output obs_t o);
    logic [31:0] fa;
    logic [63:0] fd;
    logic [2:0]  fw;
    logic        fl;
    o = '0;
    fa = '0; fd = '0; fw = '0; fl = 1'b0;
    ifu_req_i = ireq; ifu_addr_i = iaddr;
    lsu_req_i = lreq; lsu_addr_i = laddr; lsu_wdata_i = lwd; lsu_wdth_i = lw; lsu_ls_i = lls;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    o.ig = ifu_gnt_o; o.lg = lsu_gnt_o;
    if (mem_req_o) o.spur = 1'b1;
    o.mreq = 1'b1; o.stable = 1'b1;
    for (int k = 0; k <= gd; k++) begin
      tick();
      ifu_req_i = 1'($urandom_range(0, 1)); lsu_req_i = 1'($urandom_range(0, 1));
      ifu_addr_i = $urandom; lsu_addr_i = $urandom;
      lsu_wdata_i = {$urandom, $urandom}; lsu_ls_i = 1'($urandom_range(0, 1));
      lsu_wdth_i = 3'($urandom_range(0, 3));
      mem_gnt_i = (k == gd);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i = {$urandom, $urandom};
      @(negedge clk);
      if (k == 0) begin
        fa = mem_addr_o; fd = mem_wdata_o; fw = mem_wdth_o; fl = mem_ls_o;
      end else if (mem_addr_o !== fa || mem_wdata_o !== fd || mem_wdth_o !== fw || mem_ls_o !== fl) begin
        o.stable = 1'b0;
      end
      if (mem_req_o !== 1'b1) o.mreq = 1'b0;
      if (ifu_rvalid_o || lsu_rvalid_o || ifu_gnt_o || lsu_gnt_o) o.spur = 1'b1;
    end
    o.maddr = fa; o.mwdata = fd; o.mwdth = fw; o.mls = fl;
    for (int k = 0; k <= rd; k++) begin
      tick();
      mem_gnt_i = 1'($urandom_range(0, 1));
      mem_rvalid_i = (k == rd);
      mem_rdata_i = (k == rd) ? rdat : {$urandom, $urandom};
      @(negedge clk);
      if (mem_req_o || ifu_gnt_o || lsu_gnt_o) o.spur = 1'b1;
      if (k < rd) begin
        if (ifu_rvalid_o || lsu_rvalid_o) o.spur = 1'b1;
      end else begin
        o.irv = ifu_rvalid_o; o.lrv = lsu_rvalid_o;
        o.ird = ifu_rdata_o;  o.lrd = lsu_rdata_o;
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_req_i = 1'b1; lsu_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    ifu_addr_i = 32'h1234; lsu_addr_i = 32'h5678; lsu_wdata_i = '0; lsu_wdth_i = '0;
    lsu_ls_i = LS_LOAD; mem_rdata_i = 64'h55;
    tick();
    @(negedge clk);
    n_chk++;
    if ({ifu_gnt_o, lsu_gnt_o, mem_req_o, ifu_rvalid_o, lsu_rvalid_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/req/rvalid=%b want 00000",
               {ifu_gnt_o, lsu_gnt_o, mem_req_o, ifu_rvalid_o, lsu_rvalid_o});
    end
    n_chk++;
    if (mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: mem_addr_o=%h want 0", mem_addr_o);
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    last_lsu_m = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ifu_gnt_o, lsu_gnt_o, mem_req_o} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt/req=%b want 000", {ifu_gnt_o, lsu_gnt_o, mem_req_o});
    end
    tick();
  endtask

  task automatic test_basic_load();
    lsu_req_i = 1'b1; lsu_addr_i = 32'h8000_0010; lsu_ls_i = LS_LOAD; lsu_wdth_i = 3'd3;
    lsu_wdata_i = '0;
    @(negedge clk);
    n_chk++;
    if ({lsu_gnt_o, ifu_gnt_o, mem_req_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_cycle0: lsu_gnt/ifu_gnt/mem_req=%b want 100",
               {lsu_gnt_o, ifu_gnt_o, mem_req_o});
    end
    last_lsu_m = 1'b1;
    tick();
    lsu_req_i = 1'b0; lsu_addr_i = 32'hFFFF_0000; mem_gnt_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, mem_addr_o, mem_ls_o} !== {1'b1, 32'h8000_0010, LS_LOAD}) begin
      n_fail++;
      $display("FAIL basic_cycle1: mem_req=%b addr=%h ls=%b want 1 80000010 %b",
               mem_req_o, mem_addr_o, mem_ls_o, LS_LOAD);
    end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if ({lsu_rvalid_o, ifu_rvalid_o, lsu_rdata_o} !== {2'b10, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL basic_cycle2: lsu_rv=%b ifu_rv=%b rdata=%h want 1 0 deadbeef",
               lsu_rvalid_o, ifu_rvalid_o, lsu_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_arbitration();
    obs_t o;
    logic exp_lsu;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_lsu = RR ? (i % 2 == 0) : 1'b1;
      run_txn(1'b1, $urandom, 1'b1, $urandom, 64'h0, 3'd3, LS_LOAD, 0, 0, {$urandom, $urandom}, o);
      last_lsu_m = exp_lsu;
      n_chk++;
      if ({o.ig, o.lg} !== {~exp_lsu, exp_lsu}) begin
        n_fail++;
        $display("FAIL arb_grant txn%0d: ifu/lsu gnt=%b%b want %b%b", i, o.ig, o.lg, ~exp_lsu, exp_lsu);
      end
      n_chk++;
      if ({o.irv, o.lrv} !== {~exp_lsu, exp_lsu}) begin
        n_fail++;
        $display("FAIL arb_rvalid txn%0d: ifu/lsu rvalid=%b%b want %b%b", i, o.irv, o.lrv, ~exp_lsu, exp_lsu);
      end
    end
  endtask

  task automatic test_issue_hold();
    obs_t o;
    run_txn(1'b0, 32'h0, 1'b1, 32'h0000_ABC0, 64'h0, 3'd2, LS_LOAD, 5, 0, 64'h77, o);
    last_lsu_m = 1'b1;
    n_chk++;
    if ({o.mreq, o.stable, o.spur} !== 3'b110) begin
      n_fail++;
      $display("FAIL issue_hold: req_held=%b stable=%b spurious=%b want 1 1 0", o.mreq, o.stable, o.spur);
    end
    n_chk++;
    if (o.maddr !== 32'h0000_ABC0) begin
      n_fail++;
      $display("FAIL issue_hold_addr: mem_addr=%h want 0000abc0", o.maddr);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_txn(1'b0, 32'h0, 1'b1, 32'h40, 64'h1122, 3'(WDTH_BYTE), LS_STORE, 1, 1, 64'h9, o);
    last_lsu_m = 1'b1;
    n_chk++;
    if ({o.mls, o.mwdata, o.mwdth} !== {LS_STORE, 64'h1122, 3'(WDTH_BYTE)}) begin
      n_fail++;
      $display("FAIL store_fields: ls=%b wdata=%h wdth=%0d want %b 1122 %0d",
               o.mls, o.mwdata, o.mwdth, LS_STORE, WDTH_BYTE);
    end
    n_chk++;
    if ({o.lrv, o.irv} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_ack: lsu_rv=%b ifu_rv=%b want 1 0", o.lrv, o.irv);
    end
  endtask

  task automatic test_reset_in_resp();
    obs_t o;
    do_reset();
    ifu_req_i = 1'b1; ifu_addr_i = 32'h100;
    @(negedge clk);
    n_chk++;
    if (ifu_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstresp_grant: ifu_gnt=%b want 1", ifu_gnt_o);
    end
    tick();
    ifu_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD;
    last_lsu_m = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ifu_rvalid_o, lsu_rvalid_o, mem_req_o} !== 3'b0) begin
      n_fail++;
      $display("FAIL rstresp_stray: ifu_rv/lsu_rv/mem_req=%b want 000",
               {ifu_rvalid_o, lsu_rvalid_o, mem_req_o});
    end
    tick();
    idle_inputs();
    run_txn(1'b1, 32'h200, 1'b0, 32'h0, 64'h0, 3'd0, LS_LOAD, 0, 0, 64'hCAFE, o);
    n_chk++;
    if ({o.ig, o.irv, o.ird, o.maddr, o.mwdth} !== {2'b11, 64'hCAFE, 32'h200, 3'd3}) begin
      n_fail++;
      $display("FAIL rstresp_next: gnt=%b rv=%b rdata=%h addr=%h wdth=%0d want 1 1 cafe 200 3",
               o.ig, o.irv, o.ird, o.maddr, o.mwdth);
    end
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1;
    @(negedge clk);
    n_chk++;
    if ({ifu_rvalid_o, lsu_rvalid_o} !== 2'b0) begin
      n_fail++;
      $display("FAIL stray_idle: rvalid=%b want 00", {ifu_rvalid_o, lsu_rvalid_o});
    end
    tick();
    lsu_req_i = 1'b1; lsu_addr_i = 32'h300; lsu_ls_i = LS_LOAD; lsu_wdth_i = 3'd3;
    @(negedge clk);
    n_chk++;
    if ({lsu_gnt_o, lsu_rvalid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL stray_grant: lsu_gnt=%b lsu_rv=%b want 1 0", lsu_gnt_o, lsu_rvalid_o);
    end
    last_lsu_m = 1'b1;
    tick();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, lsu_rvalid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL stray_issue: mem_req=%b lsu_rv=%b want 1 0", mem_req_o, lsu_rvalid_o);
    end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_req_o, lsu_rvalid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_resp_wait: mem_req=%b lsu_rv=%b want 0 0", mem_req_o, lsu_rvalid_o);
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    n_chk++;
    if ({lsu_rvalid_o, lsu_rdata_o} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
      n_fail++;
      $display("FAIL stray_complete: lsu_rv=%b rdata=%h want 1 0123456789abcdef", lsu_rvalid_o, lsu_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0]  r;
    logic        ireq, lreq, lls, exp_lsu;
    logic [31:0] ia, la, exp_addr;
    logic [63:0] wd, rdat;
    logic [2:0]  lw, exp_wdth;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_gnt_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_chk++;
        if ({ifu_gnt_o, lsu_gnt_o, mem_req_o, ifu_rvalid_o, lsu_rvalid_o} !== 5'b0) begin
          n_fail++;
          $display("FAIL rand_idle t%0d: gnt/req/rv=%b want 00000", t,
                   {ifu_gnt_o, lsu_gnt_o, mem_req_o, ifu_rvalid_o, lsu_rvalid_o});
        end
        tick();
        idle_inputs();
      end
      r = 2'($urandom_range(1, 3));
      ireq = r[0]; lreq = r[1];
      ia = $urandom; la = $urandom; wd = {$urandom, $urandom}; rdat = {$urandom, $urandom};
      lw = 3'($urandom_range(0, 3)); lls = 1'($urandom_range(0, 1));
      exp_lsu  = lreq && (!ireq || !RR || !last_lsu_m);
      exp_addr = exp_lsu ? la : ia;
      exp_wdth = exp_lsu ? lw : 3'd3;
      run_txn(ireq, ia, lreq, la, wd, lw, lls, $urandom_range(0, 3), $urandom_range(0, 3), rdat, o);
      last_lsu_m = exp_lsu;
      n_chk++;
      if ({o.ig, o.lg} !== {~exp_lsu, exp_lsu}) begin
        n_fail++;
        $display("FAIL rand_grant t%0d: ifu/lsu gnt=%b%b want %b%b", t, o.ig, o.lg, ~exp_lsu, exp_lsu);
      end
      n_chk++;
      if ({o.mreq, o.stable, o.spur} !== 3'b110) begin
        n_fail++;
        $display("FAIL rand_protocol t%0d: req_held=%b stable=%b spurious=%b want 1 1 0",
                 t, o.mreq, o.stable, o.spur);
      end
      n_chk++;
      if ({o.maddr, o.mwdth, o.mls} !== {exp_addr, exp_wdth, exp_lsu ? lls : LS_LOAD}) begin
        n_fail++;
        $display("FAIL rand_fields t%0d: addr=%h wdth=%0d ls=%b want %h %0d %b", t,
                 o.maddr, o.mwdth, o.mls, exp_addr, exp_wdth, exp_lsu ? lls : LS_LOAD);
      end
      if (exp_lsu && lls == LS_STORE) begin
        n_chk++;
        if (o.mwdata !== wd) begin
          n_fail++;
          $display("FAIL rand_wdata t%0d: wdata=%h want %h", t, o.mwdata, wd);
        end
      end
      n_chk++;
      if ({o.irv, o.lrv} !== {~exp_lsu, exp_lsu}) begin
        n_fail++;
        $display("FAIL rand_rvalid t%0d: ifu/lsu rv=%b%b want %b%b", t, o.irv, o.lrv, ~exp_lsu, exp_lsu);
      end
      if (!(exp_lsu && lls == LS_STORE)) begin
        n_chk++;
        if ((exp_lsu ? o.lrd : o.ird) !== rdat) begin
          n_fail++;
          $display("FAIL rand_rdata t%0d: rdata=%h want %h", t, exp_lsu ? o.lrd : o.ird, rdat);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_load();
    test_arbitration();
    test_issue_hold();
    test_store();
    test_reset_in_resp();
    test_stray_rvalid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
